score_counter: RTL

- Scoring engine for the whack-a-mole game.
- Consumes single-cycle hit/miss event pulses from the mole/button judge logic and start/game-over pulses from the game timer.
- Maintains the current 16-bit score, the consecutive-hit combo, and a session high score.
- Its `score` output drives the 7-segment score display stage directly. That stage clamps at 999, so this block saturates only at 16-bit full scale.

---
 rtl/whack_pkg.sv | 19 +
 rtl/sat_addsub.sv | 25 ++
 rtl/score_counter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/whack_pkg.sv
// Shared whack-a-mole definitions: game FSM encoding, datapath widths and point values
// used by the scoring, timer and judge blocks.
package whack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int SCORE_W      = 16;
  localparam int COMBO_W      = 8;

  localparam int HIT_POINTS   = 10;
  localparam int MISS_PENALTY = 5;
  localparam int COMBO_STEP   = 5;
  localparam int COMBO_BONUS  = 20;

endpackage

// File: rtl/sat_addsub.sv
// Combinational unsigned add/subtract that clamps at all-ones on overflow
// and at zero on underflow.
module sat_addsub #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_y
);

  logic [W:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  always_comb begin
    o_y = '0;
    if (i_sub) begin
      o_y = (i_b > i_a) ? '0 : (i_a - i_b);
    end else begin
      o_y = w_sum[W] ? '1 : w_sum[W-1:0];
    end
  end

endmodule

// File: rtl/score_counter.sv
// Whack-a-mole scoring engine: IDLE/PLAY/OVER game FSM with score, hit combo
// and session high score, all outputs registered.
module score_counter #(
  parameter int SCORE_W      = whack_pkg::SCORE_W,
  parameter int HIT_POINTS   = whack_pkg::HIT_POINTS,
  parameter int MISS_PENALTY = whack_pkg::MISS_PENALTY,
  parameter int COMBO_STEP   = whack_pkg::COMBO_STEP,
  parameter int COMBO_BONUS  = whack_pkg::COMBO_BONUS,
  parameter int COMBO_W      = whack_pkg::COMBO_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               game_over,
  input  logic               hit,
  input  logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [COMBO_W-1:0] combo,
  output logic               playing,
  output logic               new_high
);

  import whack_pkg::*;

  localparam logic [COMBO_W-1:0] COMBO_MAX  = '1;
  localparam logic [COMBO_W-1:0] STEP_C     = COMBO_W'(COMBO_STEP);
  localparam logic [SCORE_W-1:0] HIT_C      = SCORE_W'(HIT_POINTS);
  localparam logic [SCORE_W-1:0] HIT_BONUS_C = SCORE_W'(HIT_POINTS + COMBO_BONUS);
  localparam logic [SCORE_W-1:0] MISS_C     = SCORE_W'(MISS_PENALTY);

  state_e             r_state;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high;
  logic [COMBO_W-1:0] r_combo;
  logic               r_playing;
  logic               r_new_high;

  state_e             w_state_n;
  logic [SCORE_W-1:0] w_score_n;
  logic [SCORE_W-1:0] w_high_n;
  logic [COMBO_W-1:0] w_combo_n;
  logic               w_new_high_n;

  logic [COMBO_W-1:0] w_combo_inc;
  logic               w_bonus;
  logic [SCORE_W-1:0] w_delta;
  logic [SCORE_W-1:0] w_score_upd;

  // A bonus is only earned on the hit that actually advances the combo,
  // so a combo parked at full scale stops paying out.
  assign w_combo_inc = (r_combo == COMBO_MAX) ? r_combo : r_combo + 1'b1;
  assign w_bonus     = (r_combo != COMBO_MAX) && ((w_combo_inc % STEP_C) == '0);
  assign w_delta     = miss ? MISS_C : (w_bonus ? HIT_BONUS_C : HIT_C);

  sat_addsub #(
    .W(SCORE_W)
  ) u_sat_addsub (
    .i_a  (r_score),
    .i_b  (w_delta),
    .i_sub(miss),
    .o_y  (w_score_upd)
  );

  always_comb begin
    w_state_n    = r_state;
    w_score_n    = r_score;
    w_high_n     = r_high;
    w_combo_n    = r_combo;
    w_new_high_n = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_score_n = '0;
          w_combo_n = '0;
          w_state_n = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (start) begin
          w_score_n = '0;
          w_combo_n = '0;
        end else if (game_over) begin
          w_state_n = ST_OVER;
        end else if (miss) begin
          w_score_n = w_score_upd;
          w_combo_n = '0;
        end else if (hit) begin
          w_score_n = w_score_upd;
          w_combo_n = w_combo_inc;
        end
      end
      ST_OVER: begin
        // Single-cycle settle state; a start landing here is dropped.
        w_state_n = ST_IDLE;
        if (r_score > r_high) begin
          w_high_n     = r_score;
          w_new_high_n = 1'b1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_score    <= '0;
      r_high     <= '0;
      r_combo    <= '0;
      r_playing  <= 1'b0;
      r_new_high <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_score    <= w_score_n;
      r_high     <= w_high_n;
      r_combo    <= w_combo_n;
      r_playing  <= (w_state_n == ST_PLAY);
      r_new_high <= w_new_high_n;
    end
  end

  assign score      = r_score;
  assign high_score = r_high;
  assign combo      = r_combo;
  assign playing    = r_playing;
  assign new_high   = r_new_high;

endmodule
